// File: rtl/soft_grand_ranker_pkg.sv
// Shared types and defaults for the Soft GRAND front end: reliability record,
// ranker FSM states and the default code/LLR/rank widths.
package grand_pkg;

  localparam int N     = 8;
  localparam int LLR_W = 6;
  localparam int K_W   = 9;

  typedef struct packed {
    logic [LLR_W-1:0] mag;
    logic [K_W-1:0]   pos;
  } rel_t;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    HOLD
  } rank_state_t;

endpackage

// File: rtl/soft_grand_ranker_if.sv
// LLR input stream and rank-vector result bundle between the channel front end
// and the Soft GRAND decoder.
interface soft_grand_ranker_if #(
  parameter int LLR_W = 6,
  parameter int K_W   = 9
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [LLR_W-1:0] in_llr;
  logic                    out_valid;
  logic                    out_ready;
  logic [0:7]              c_hat;
  logic [K_W-1:0]          k_0, k_1, k_2, k_3, k_4, k_5, k_6, k_7;

  modport master (
    output in_valid, in_llr, out_ready,
    input  in_ready, out_valid, c_hat,
    input  k_0, k_1, k_2, k_3, k_4, k_5, k_6, k_7
  );

  modport slave (
    input  in_valid, in_llr, out_ready,
    output in_ready, out_valid, c_hat,
    output k_0, k_1, k_2, k_3, k_4, k_5, k_6, k_7
  );
endinterface

// File: rtl/soft_grand_ranker_cmp_swap.sv
// Compare-exchange on two reliability records: the less reliable one leaves on
// lo_o, ties broken by the lower bit position.
module grand_cmp_swap
  import grand_pkg::*;
(
  input  rel_t a_i,
  input  rel_t b_i,
  output rel_t lo_o,
  output rel_t hi_o
);
  logic swap;

  assign swap = (a_i.mag > b_i.mag) ||
                ((a_i.mag == b_i.mag) && (a_i.pos > b_i.pos));
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;
endmodule

// File: rtl/soft_grand_ranker.sv
// Soft GRAND front end: captures 8 serial LLRs, forms hard decisions and ranks
// bit positions by ascending reliability with an odd-even transposition sort.
module soft_grand_ranker
  import grand_pkg::*;
#(
  parameter int N     = 8,
  parameter int LLR_W = 6,
  parameter int K_W   = 9
) (
  input logic               clk,
  input logic               rst_n,
  soft_grand_ranker_if.slave bus
);
  rank_state_t      state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       phase_q, phase_d;
  rel_t             slot_q [N];
  rel_t             slot_d [N];
  rel_t             sorted [N];
  rel_t             cmp_a  [4];
  rel_t             cmp_b  [4];
  rel_t             cmp_lo [4];
  rel_t             cmp_hi [4];
  logic [0:N-1]     c_hat_q, c_hat_d;
  logic [K_W-1:0]   k_q [N];
  logic [K_W-1:0]   k_d [N];
  logic [LLR_W-1:0] llr_mag;

  // -2^(LLR_W-1) negates to itself, which read unsigned is exactly 2^(LLR_W-1)
  assign llr_mag = bus.in_llr[LLR_W-1] ? $unsigned(-bus.in_llr) : $unsigned(bus.in_llr);

  // Odd phases pair (1,2),(3,4),(5,6); the fourth comparator's result is unused
  // there and slots 0 and 7 pass straight through.
  always_comb begin
    if (phase_q[0]) begin
      cmp_a  = '{slot_q[1], slot_q[3], slot_q[5], slot_q[0]};
      cmp_b  = '{slot_q[2], slot_q[4], slot_q[6], slot_q[7]};
      sorted = '{slot_q[0], cmp_lo[0], cmp_hi[0], cmp_lo[1],
                 cmp_hi[1], cmp_lo[2], cmp_hi[2], slot_q[7]};
    end else begin
      cmp_a  = '{slot_q[0], slot_q[2], slot_q[4], slot_q[6]};
      cmp_b  = '{slot_q[1], slot_q[3], slot_q[5], slot_q[7]};
      sorted = '{cmp_lo[0], cmp_hi[0], cmp_lo[1], cmp_hi[1],
                 cmp_lo[2], cmp_hi[2], cmp_lo[3], cmp_hi[3]};
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_cmp
    grand_cmp_swap u_cmp (
      .a_i  (cmp_a[g]),
      .b_i  (cmp_b[g]),
      .lo_o (cmp_lo[g]),
      .hi_o (cmp_hi[g])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    slot_d  = slot_q;
    c_hat_d = c_hat_q;
    k_d     = k_q;
    unique case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          c_hat_d[idx_q]     = bus.in_llr[LLR_W-1];
          slot_d[idx_q].mag  = llr_mag;
          slot_d[idx_q].pos  = K_W'(idx_q) + K_W'(1);
          idx_d              = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = SORT;
            phase_d = '0;
          end
        end
      end
      SORT: begin
        slot_d  = sorted;
        phase_d = phase_q + 3'd1;
        if (phase_q == 3'd7) begin
          state_d = HOLD;
          for (int unsigned i = 0; i < N; i++) k_d[i] = sorted[i].pos;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      phase_q <= '0;
      c_hat_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        slot_q[i] <= '0;
        k_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      c_hat_q <= c_hat_d;
      slot_q  <= slot_d;
      k_q     <= k_d;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.c_hat     = c_hat_q;
  assign bus.k_0       = k_q[0];
  assign bus.k_1       = k_q[1];
  assign bus.k_2       = k_q[2];
  assign bus.k_3       = k_q[3];
  assign bus.k_4       = k_q[4];
  assign bus.k_5       = k_q[5];
  assign bus.k_6       = k_q[6];
  assign bus.k_7       = k_q[7];
endmodule

// File: tb/tb_soft_grand_ranker.sv
// Scoreboard bench for soft_grand_ranker: a reference sort of each frame is
// queued at stimulus time and compared when the result is handed off.
module tb_soft_grand_ranker;
  import grand_pkg::*;

  typedef logic signed [5:0] frame_t [8];
  typedef struct packed {
    logic [0:7]       c;
    logic [8*K_W-1:0] k;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  soft_grand_ranker_if #(.LLR_W(LLR_W), .K_W(K_W)) bus ();

  soft_grand_ranker #(.N(N), .LLR_W(LLR_W), .K_W(K_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb [$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8*K_W-1:0] k_vec();
    return {bus.k_0, bus.k_1, bus.k_2, bus.k_3, bus.k_4, bus.k_5, bus.k_6, bus.k_7};
  endfunction

  // Reference: insertion sort of positions keyed by (|llr|, position)
  function automatic exp_t model(input frame_t llr);
    exp_t e;
    int   m [8];
    int   ord [8];
    int   t;
    e = '0;
    for (int i = 0; i < 8; i++) begin
      m[i]   = (llr[i] < 0) ? -int'(llr[i]) : int'(llr[i]);
      e.c[i] = (llr[i] < 0);
      ord[i] = i + 1;
    end
    for (int i = 1; i < 8; i++) begin
      for (int j = i; j > 0; j--) begin
        if (m[ord[j-1]-1] > m[ord[j]-1] ||
            (m[ord[j-1]-1] == m[ord[j]-1] && ord[j-1] > ord[j])) begin
          t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
        end
      end
    end
    for (int i = 0; i < 8; i++) e.k[(7-i)*K_W +: K_W] = K_W'(ord[i]);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        check("c_hat", bus.c_hat, e.c);
        check("k_vec", k_vec(), e.k);
      end
    end
  end

  task automatic drive_beat(input logic signed [5:0] v);
    int w;
    bus.in_valid = 1'b1;
    bus.in_llr   = v;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input frame_t llr, input bit bubbles);
    for (int i = 0; i < 8; i++) begin
      if (bubbles) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      drive_beat(llr[i]);
    end
    bus.in_valid = 1'b0;
    sb.push_back(model(llr));
  endtask

  task automatic wait_result(input string tag);
    int c;
    c = 0;
    while (!bus.out_valid && c < 20) begin
      @(posedge clk); #1; c++;
    end
    check(tag, c, 8);
    if (bus.out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_c_hat"},     bus.c_hat,     0);
    check({tag, "_k"},         k_vec(),       0);
  endtask

  initial begin
    frame_t           mixed, ties, extreme;
    logic [0:7]       c_snap;
    logic [8*K_W-1:0] k_snap;

    mixed   = '{6'sd20, -6'sd3, 6'sd15, 6'sd9, -6'sd7, 6'sd11, -6'sd14, 6'sd2};
    ties    = '{default: 6'sd5};
    extreme = '{6'sd1, 6'sd1, 6'sd1, 6'b100000, 6'sd1, 6'sd1, 6'sd1, 6'sd1};

    bus.in_valid  = 1'b0;
    bus.in_llr    = '0;
    bus.out_ready = 1'b1;
    #2;
    check_reset_values("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_frame(mixed, 1'b0);
    wait_result("mixed_latency");
    send_frame(ties, 1'b0);
    wait_result("ties_latency");
    send_frame(extreme, 1'b0);
    wait_result("extreme_latency");
    send_frame(mixed, 1'b1);
    wait_result("bubbles_latency");

    // Abort a half-loaded frame; outputs still hold the mixed result beforehand
    for (int i = 0; i < 4; i++) drive_beat(extreme[i]);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(ties, 1'b0);
    wait_result("after_reset_latency");

    bus.out_ready = 1'b0;
    send_frame(mixed, 1'b0);
    wait_result("bp_latency");
    c_snap = bus.c_hat;
    k_snap = k_vec();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_llr   = -6'sd1;
      @(posedge clk); #1;
      check("bp_c_stable",  bus.c_hat,     c_snap);
      check("bp_k_stable",  k_vec(),       k_snap);
      check("bp_in_ready",  bus.in_ready,  0);
      check("bp_out_valid", bus.out_valid, 1);
    end
    check("bp_c_value", c_snap, 8'b0100_1010);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready",  bus.in_ready,  1);
    check("bp_release_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    send_frame(ties, 1'b0);
    wait_result("bp_second_latency");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/soft_grand_ranker.md
# soft_grand_ranker

Upstream front end of the Soft GRAND decoder. Accepts one 8-bit frame of channel LLRs serially, forms the hard-decision word `c_hat`, and sorts bit positions by reliability into the rank vector `k_0..k_7`. That vector is the permutation SoftGrand uses to order its error-pattern search. A valid/ready handshake sits on both sides, and results are held until the decoder accepts them.

## Interface
Parameters:
- `N`, 8: code length. Fixed at 8; other values are unsupported.
- `LLR_W`, 6: width of the signed input LLR.
- `K_W`, 9: width of each rank output.

Ports:
- `clk`, input, 1: the single clock. Everything is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: an LLR beat is present.
- `in_ready`, output, 1: the block can accept a beat.
- `in_llr`, input, LLR_W, signed: LLR of the current bit. Bits arrive in order 0..7, where bit 0 maps to `c_hat[0]`.
- `out_valid`, output, 1: `c_hat` and `k_*` are valid.
- `out_ready`, input, 1: the decoder accepts the result.
- `c_hat`, output, [0:7]: hard decisions.
- `k_0` … `k_7`, output, K_W each: rank vector. `k_i` is the 1-based position of the i-th least reliable bit, zero-extended.

## Operation
- FSM states:
  - LOAD. `in_ready`=1. Each `in_valid` beat stores:
    - `c_hat[idx] = in_llr[LLR_W-1]`, so negative LLR gives 1;
    - `mag[idx] = |in_llr|` as an LLR_W-bit unsigned value (−2^(LLR_W−1) maps to 2^(LLR_W−1), with no saturation);
    - `pos[idx] = idx+1`.
    
    After beat 7, go to SORT with `phase`=0. Cycles with `in_valid`=0 are bubbles and change nothing.
  - SORT. `in_ready`=0. Runs 8 odd-even transposition phases, one per cycle:
    - even phases compare pairs (0,1),(2,3),(4,5),(6,7);
    - odd phases compare pairs (1,2),(3,4),(5,6).
    
    A pair (a,b) swaps iff `mag_a > mag_b`, or `mag_a == mag_b` and `pos_a > pos_b`. Ties therefore resolve by ascending position. After phase 7, go to HOLD.
  - HOLD. `out_valid`=1, and `k_i = pos[i]` after sorting. Outputs stay stable while `out_ready`=0. On `out_valid & out_ready`, go to LOAD.
- Beat index and phase counter are 3-bit and wrap 7→0.
- `in_valid` is ignored outside LOAD. There is no overflow and no error flag.
- `c_hat` and `k_*` are registered and only change on the transitions above. Between frames they keep their last value.

## Timing
- Reset values: state LOAD, `in_ready`=1, `out_valid`=0, `c_hat`=0, all `k_i`=0, internal counters 0.
- Throughput: one beat per cycle while in LOAD.
- Latency: the 8th beat is accepted at edge T. The SORT phases occur at edges T+1..T+8. `out_valid` is high from edge T+8.
- Handshake:
  - The handshake at edge H moves the FSM to LOAD, so `in_ready`=1 after H.
  - A beat presented in the same cycle as the handshake is not accepted, because `in_ready` was 0 during that cycle.
- Reset asserted at any point aborts the frame and forces the reset values immediately. No partial frame survives reset.

## Structure
- Package `grand_pkg` holds:
  - `N`, `K_W` and `LLR_W` defaults;
  - typedef `rel_t` = struct {`mag` [LLR_W-1:0], `pos` [K_W-1:0]};
  - state enum `rank_state_t` {LOAD, SORT, HOLD}.
- Sub-module `grand_cmp_swap`: a combinational compare-exchange on two `rel_t` values, using the tie rule above. Instantiate it 4 times and select the pairing by phase parity. Slot 0 and slot 7 pass through on odd phases.

## Test plan
- **Mixed frame.** LLRs +20,−3,+15,+9,−7,+11,−14,+2 with no gaps → `c_hat`=0100_1010, k=8,2,5,4,6,7,3,1. `out_valid` rises exactly 8 cycles after the last beat.
- **All ties.** Eight beats of +5 → `c_hat`=0000_0000, k=1,2,3,4,5,6,7,8.
- **Extreme value.** Bit 3 = −32, all others +1 → `c_hat`=0001_0000, k=1,2,3,5,6,7,8,4.
- **Backpressure.** Run the mixed frame with `out_ready`=0 for 5 cycles in HOLD, and drive `in_valid`=1 throughout. Outputs stay stable, `in_ready`=0, and no beat is captured. After the handshake, a second frame of all +5 gives k=1..8.
- **Bubbles.** The mixed frame with `in_valid` low for 1–3 cycles between beats gives the identical result.
- **Reset mid-frame.** Drop `rst_n` after 4 beats → reset values appear immediately. The next full ties frame gives k=1..8 with no contamination from the aborted frame.
